// File: rtl/mem_word_ctrl.sv
// Byte-serial load/store sequencer in front of a byte-wide memory.
// Define MEM_CTRL_ALIGN_CHECK_EN to reject misaligned half/word requests.
module mem_word_ctrl #(
  parameter int ADDR_W = 8,
  parameter int BYTE_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [4*BYTE_W-1:0] req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [4*BYTE_W-1:0] resp_rdata,
  output logic                resp_err,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_write_en,
  output logic                mem_read_en,
  output logic [BYTE_W-1:0]   mem_write_in,
  input  logic [BYTE_W-1:0]   mem_read_out
);

  localparam int DATA_W = 4 * BYTE_W;

  typedef enum logic [1:0] {
    IDLE,
    BEAT,
    RESP
  } state_t;

  state_t state, state_nx;

  logic              we_q;
  logic              err_q;
  logic [1:0]        beat_q;
  logic [1:0]        last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              illegal;
  logic              misalign;
  logic              accept;
  logic              beat_last;
  logic [1:0]        last_nx;
  logic [1:0]        beat_nx;
  logic [ADDR_W-1:0] base;
  logic [DATA_W-1:0] wsrc;
  logic              wsel_we;
  logic [ADDR_W-1:0] addr_nx;
  logic              mwe_nx;
  logic              mre_nx;
  logic [BYTE_W-1:0] win_nx;

`ifdef MEM_CTRL_ALIGN_CHECK_EN
  assign misalign = (req_size == 2'd1 && req_addr[0])
                 || (req_size == 2'd2 && req_addr[1:0] != 2'd0);
`else
  assign misalign = 1'b0;
`endif

  assign illegal   = (req_size == 2'd3) || misalign;
  assign accept    = (state == IDLE) && req_valid;
  assign beat_last = (beat_q == last_q);

  always_comb begin
    last_nx = 2'd0;
    unique case (1'b1)
      req_size == 2'd1: last_nx = 2'd1;
      req_size == 2'd2: last_nx = 2'd3;
      default:          last_nx = 2'd0;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req_valid) state_nx = illegal ? RESP : BEAT;
      BEAT:    if (beat_last) state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Memory controls are computed one cycle ahead so they leave a register
  always_comb begin
    beat_nx = (state == IDLE) ? 2'd0 : beat_q + 2'd1;
    base    = (state == IDLE) ? req_addr : addr_q;
    wsel_we = (state == IDLE) ? req_we : we_q;
    wsrc    = (state == IDLE) ? req_wdata : wdata_q;
    addr_nx = '0;
    mwe_nx  = 1'b0;
    mre_nx  = 1'b0;
    win_nx  = '0;
    if (state_nx == BEAT) begin
      addr_nx = base + ADDR_W'(beat_nx);
      mwe_nx  = wsel_we;
      mre_nx  = !wsel_we;
      if (wsel_we)
        win_nx = wsrc[int'(beat_nx)*BYTE_W +: BYTE_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      beat_q       <= 2'd0;
      last_q       <= 2'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      mem_addr     <= '0;
      mem_write_en <= 1'b0;
      mem_read_en  <= 1'b0;
      mem_write_in <= '0;
    end else begin
      mem_addr     <= addr_nx;
      mem_write_en <= mwe_nx;
      mem_read_en  <= mre_nx;
      mem_write_in <= win_nx;
      if (accept) begin
        we_q    <= req_we;
        err_q   <= illegal;
        beat_q  <= 2'd0;
        last_q  <= last_nx;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rdata_q <= '0;
      end else if (state == BEAT) begin
        if (!we_q)
          rdata_q[int'(beat_q)*BYTE_W +: BYTE_W] <= mem_read_out;
        beat_q <= beat_q + 2'd1;
      end
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
